// File: rtl/inst_fetch_pkg.sv
// Types and helpers shared by the instruction fetch stage and its pc register.
package inst_fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    SEL_IDLE   = 3'd0,
    SEL_FLUSH  = 3'd1,
    SEL_STALL  = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_SEQ    = 3'd4
  } next_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/defines.vh
// Shared bus widths and constant words for the pipeline front end.
`ifndef DEFINES_VH
`define DEFINES_VH

`define InstAddrBus 31:0
`define InstBus     31:0
`define ZEROWORD    32'h0000_0000
`define ChipEnable  1'b1
`define ChipDisable 1'b0

`endif

// File: rtl/inst_fetch_pc_reg.sv
// Fetch program counter, ROM chip enable and next-pc priority mux.
`include "defines.vh"

module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [`InstAddrBus] new_pc,
  input  logic                branch_flag,
  input  logic [`InstAddrBus] branch_target,
  output logic [`InstAddrBus] pc,
  output logic                rom_ce,
  output next_sel_e           sel
);

  logic [31:0] pc_r;
  logic        rom_ce_r;
  next_sel_e   sel_s;

  // Next-pc source: flush beats stall beats branch beats sequential.
  always_comb begin
    sel_s = SEL_IDLE;
    if (rom_ce_r == `ChipDisable) begin
      sel_s = SEL_IDLE;
    end else if (flush) begin
      sel_s = SEL_FLUSH;
    end else if (stall) begin
      sel_s = SEL_STALL;
    end else if (branch_flag) begin
      sel_s = SEL_BRANCH;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // PC and chip-enable state; the first edge out of reset only enables the ROM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= RESET_PC;
      rom_ce_r <= `ChipDisable;
    end else begin
      rom_ce_r <= `ChipEnable;
      case (sel_s)
        SEL_FLUSH:  pc_r <= word_align(new_pc);
        SEL_BRANCH: pc_r <= word_align(branch_target);
        SEL_SEQ:    pc_r <= pc_r + PC_STEP;
        SEL_STALL:  pc_r <= pc_r;
        SEL_IDLE:   pc_r <= pc_r;
        default:    pc_r <= pc_r;
      endcase
    end
  end

  assign pc     = pc_r;
  assign rom_ce = rom_ce_r;
  assign sel    = sel_s;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: pc_reg plus the IF/ID pipeline register.
// Define BRANCH_DELAY_SLOT_EN to keep the instruction fetched alongside a taken branch.
`include "defines.vh"

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [`InstAddrBus] new_pc,
  input  logic                branch_flag,
  input  logic [`InstAddrBus] branch_target,
  output logic                rom_ce,
  output logic [`InstAddrBus] rom_addr,
  input  logic [`InstBus]     rom_inst,
  output logic [`InstAddrBus] id_pc,
  output logic [`InstBus]     id_inst,
  output logic                id_valid
);

  logic [31:0] pc_s;
  next_sel_e   sel_s;
  logic [31:0] id_pc_r;
  logic [31:0] id_inst_r;
  logic        id_valid_r;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc_s),
    .rom_ce       (rom_ce),
    .sel          (sel_s)
  );

  assign rom_addr = {2'b00, pc_s[31:2]};

  // IF/ID register: capture, hold or insert a bubble depending on the pc source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_r    <= 32'h0000_0000;
      id_inst_r  <= `ZEROWORD;
      id_valid_r <= 1'b0;
    end else begin
      case (sel_s)
        SEL_SEQ: begin
          id_pc_r    <= pc_s;
          id_inst_r  <= rom_inst;
          id_valid_r <= 1'b1;
        end
        SEL_BRANCH: begin
`ifdef BRANCH_DELAY_SLOT_EN
          id_pc_r    <= pc_s;
          id_inst_r  <= rom_inst;
          id_valid_r <= 1'b1;
`else
          id_pc_r    <= 32'h0000_0000;
          id_inst_r  <= `ZEROWORD;
          id_valid_r <= 1'b0;
`endif
        end
        SEL_STALL: begin
          id_pc_r    <= id_pc_r;
          id_inst_r  <= id_inst_r;
          id_valid_r <= id_valid_r;
        end
        SEL_FLUSH, SEL_IDLE: begin
          id_pc_r    <= 32'h0000_0000;
          id_inst_r  <= `ZEROWORD;
          id_valid_r <= 1'b0;
        end
        default: begin
          id_pc_r    <= 32'h0000_0000;
          id_inst_r  <= `ZEROWORD;
          id_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign id_pc    = id_pc_r;
  assign id_inst  = id_inst_r;
  assign id_valid = id_valid_r;

endmodule
